inst_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the program-counter addressing of the combinational instruction ROM (A-bit address, W-bit word). It runs a program from a start address and registers each fetched word into an instruction register for the decoder. It applies branch, jump and halt redirects from the execute stage, supports stalls, and reports completion plus a cycle count to the testbench.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/inst_fetch_ctrl_if.sv | 34 +++
 rtl/inst_fetch_ctrl_next_pc.sv | 25 ++
 rtl/inst_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch controller, decoder and bench.
package fetch_pkg;

    localparam int unsigned A   = 10;
    localparam int unsigned W   = 9;
    localparam int unsigned OFS = 6;
    localparam int unsigned CW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_START  = 2'd3
    } pc_sel_e;

    // Sign-extend a relative branch offset to address width.
    function automatic logic [A-1:0] sext_ofs(input logic [OFS-1:0] ofs);
        return {{(A-OFS){ofs[OFS-1]}}, ofs};
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Control, redirect and ROM signals between the fetch controller and its environment.
interface fetch_if;
    import fetch_pkg::*;

    logic           start;
    logic [A-1:0]   start_addr;
    logic           stall;
    logic           halt;
    logic           branch_taken;
    logic [OFS-1:0] branch_ofs;
    logic           jump;
    logic [A-1:0]   jump_addr;
    logic [A-1:0]   inst_address;
    logic [W-1:0]   inst_in;
    logic [W-1:0]   inst_out;
    logic [A-1:0]   ir_pc;
    logic           inst_valid;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cycle_count;

    modport master (
        output start, start_addr, stall, halt, branch_taken, branch_ofs,
               jump, jump_addr, inst_in,
        input  inst_address, inst_out, ir_pc, inst_valid, busy, done, cycle_count
    );

    modport slave (
        input  start, start_addr, stall, halt, branch_taken, branch_ofs,
               jump, jump_addr, inst_in,
        output inst_address, inst_out, ir_pc, inst_valid, busy, done, cycle_count
    );

endinterface

// File: rtl/inst_fetch_ctrl_next_pc.sv
// Combinational next-PC select: sequential, absolute jump, relative branch or start address.
module next_pc
    import fetch_pkg::*;
(
    input  pc_sel_e        sel,
    input  logic [A-1:0]   pc,
    input  logic [A-1:0]   ir_pc,
    input  logic [A-1:0]   jump_addr,
    input  logic [A-1:0]   start_addr,
    input  logic [OFS-1:0] branch_ofs,
    output logic [A-1:0]   npc_c
);

    // All arithmetic is A-bit so both increment and branch wrap naturally.
    always_comb begin
        npc_c = pc + A'(1);
        case (sel)
            PC_JUMP:   npc_c = jump_addr;
            PC_BRANCH: npc_c = ir_pc + sext_ofs(branch_ofs);
            PC_START:  npc_c = start_addr;
            default:   npc_c = pc + A'(1);
        endcase
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, instruction register, redirects, stall and run counter.
module inst_fetch_ctrl
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    fetch_if.slave bus
);

    state_e         state;
    state_e         state_nxt;

    logic [A-1:0]   pc;
    logic [W-1:0]   ir;
    logic [A-1:0]   ir_pc;
    logic           inst_valid;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cycle_count;

    logic           pc_load;
    pc_sel_e        pc_sel;
    logic           ir_load;
    logic           valid_clr;
    logic           cnt_clr;
    logic           cnt_inc;
    logic [A-1:0]   npc_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; redirects only count when they refer to a live instruction
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN: if (!bus.stall && inst_valid && bus.halt) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath control, priority halt > jump > branch > sequential
    always_comb begin
        pc_load   = 1'b0;
        pc_sel    = PC_SEQ;
        ir_load   = 1'b0;
        valid_clr = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    pc_load   = 1'b1;
                    pc_sel    = PC_START;
                    valid_clr = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_inc = 1'b1;
                if (!bus.stall) begin
                    if (inst_valid && bus.halt) begin
                        valid_clr = 1'b1;
                    end else if (inst_valid && bus.jump) begin
                        pc_load   = 1'b1;
                        pc_sel    = PC_JUMP;
                        valid_clr = 1'b1;
                    end else if (inst_valid && bus.branch_taken) begin
                        pc_load   = 1'b1;
                        pc_sel    = PC_BRANCH;
                        valid_clr = 1'b1;
                    end else begin
                        pc_load = 1'b1;
                        ir_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    next_pc u_next_pc (
        .sel        (pc_sel),
        .pc         (pc),
        .ir_pc      (ir_pc),
        .jump_addr  (bus.jump_addr),
        .start_addr (bus.start_addr),
        .branch_ofs (bus.branch_ofs),
        .npc_c      (npc_c)
    );

    // PC, IR, status flags and saturating run counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            ir          <= '0;
            ir_pc       <= '0;
            inst_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (pc_load) pc <= npc_c;
            if (ir_load) begin
                ir         <= bus.inst_in;
                ir_pc      <= pc;
                inst_valid <= 1'b1;
            end else if (valid_clr) begin
                inst_valid <= 1'b0;
            end
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            if (cnt_clr)                          cycle_count <= '0;
            else if (cnt_inc && cycle_count != '1) cycle_count <= cycle_count + CW'(1);
        end
    end

    assign bus.inst_address = pc;
    assign bus.inst_out     = ir;
    assign bus.ir_pc        = ir_pc;
    assign bus.inst_valid   = inst_valid;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.cycle_count  = cycle_count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a combinational ROM model.
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_if bus ();

    inst_fetch_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [W-1:0] rom_f(input logic [A-1:0] a);
        logic [A-1:0] t;
        t = (a * A'(13)) ^ (a >> 3);
        return W'(t + A'(7));
    endfunction

    assign bus.inst_in = rom_f(bus.inst_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.start_addr = '0; bus.stall = 1'b0; bus.halt = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_ofs = '0; bus.jump = 1'b0; bus.jump_addr = '0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_pc",    32'(bus.inst_address), 32'd0);
        check("rst_ir",    32'(bus.inst_out),     32'd0);
        check("rst_valid", 32'(bus.inst_valid),   32'd0);
        check("rst_busy",  32'(bus.busy),         32'd0);
        check("rst_done",  32'(bus.done),         32'd0);
        check("rst_cnt",   32'(bus.cycle_count),  32'd0);

        // Sequential run from 0, halt on the word at address 3
        bus.start = 1'b1; bus.start_addr = 10'd0;
        step();
        bus.start = 1'b0;
        check("seq_start_pc",    32'(bus.inst_address), 32'd0);
        check("seq_start_busy",  32'(bus.busy),         32'd1);
        check("seq_start_valid", 32'(bus.inst_valid),   32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq_ir",    32'(bus.inst_out),   32'(rom_f(A'(i))));
            check("seq_irpc",  32'(bus.ir_pc),      32'(i));
            check("seq_valid", 32'(bus.inst_valid), 32'd1);
        end
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("halt_done",  32'(bus.done),         32'd1);
        check("halt_busy",  32'(bus.busy),         32'd0);
        check("halt_valid", 32'(bus.inst_valid),   32'd0);
        check("halt_cnt",   32'(bus.cycle_count),  32'd5);
        check("halt_pc",    32'(bus.inst_address), 32'd4);
        step();
        check("done_hold",  32'(bus.done),         32'd1);
        check("done_cnt",   32'(bus.cycle_count),  32'd5);

        // Backward branch from IrPC=10 by -4, started from DONE
        bus.start = 1'b1; bus.start_addr = 10'd8;
        step();
        bus.start = 1'b0;
        check("br_done_clr", 32'(bus.done), 32'd0);
        step(); step(); step();
        check("br_irpc10", 32'(bus.ir_pc), 32'd10);
        bus.branch_taken = 1'b1; bus.branch_ofs = 6'b111100;
        step();
        bus.branch_taken = 1'b0;
        check("br_bubble", 32'(bus.inst_valid),   32'd0);
        check("br_pc",     32'(bus.inst_address), 32'd6);
        step();
        check("br_ir",    32'(bus.inst_out),   32'(rom_f(10'd6)));
        check("br_irpc",  32'(bus.ir_pc),      32'd6);
        check("br_valid", 32'(bus.inst_valid), 32'd1);

        // Jump and branch together: jump wins
        bus.jump = 1'b1; bus.jump_addr = 10'h200;
        bus.branch_taken = 1'b1; bus.branch_ofs = 6'd5;
        step();
        bus.jump = 1'b0; bus.branch_taken = 1'b0;
        check("jb_bubble", 32'(bus.inst_valid),   32'd0);
        check("jb_pc",     32'(bus.inst_address), 32'h200);
        bus.halt = 1'b1;  // refers to a bubble, must be ignored
        step();
        bus.halt = 1'b0;
        check("jb_irpc",     32'(bus.ir_pc),      32'h200);
        check("jb_ir",       32'(bus.inst_out),   32'(rom_f(10'h200)));
        check("bubble_halt", 32'(bus.busy),       32'd1);
        check("jb_cnt",      32'(bus.cycle_count), 32'd7);

        // Stall 3 cycles with a jump pending
        bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_addr = 10'h055;
        step(); step(); step();
        bus.stall = 1'b0; bus.jump = 1'b0;
        check("stall_ir",    32'(bus.inst_out),     32'(rom_f(10'h200)));
        check("stall_irpc",  32'(bus.ir_pc),        32'h200);
        check("stall_pc",    32'(bus.inst_address), 32'h201);
        check("stall_valid", 32'(bus.inst_valid),   32'd1);
        check("stall_cnt",   32'(bus.cycle_count),  32'd10);
        step();
        check("post_stall_irpc", 32'(bus.ir_pc),       32'h201);
        check("post_stall_cnt",  32'(bus.cycle_count), 32'd11);

        // Start while running is ignored
        bus.start = 1'b1; bus.start_addr = 10'h003;
        step();
        bus.start = 1'b0;
        check("run_start_pc",   32'(bus.inst_address), 32'h203);
        check("run_start_irpc", 32'(bus.ir_pc),        32'h202);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("arst_pc",    32'(bus.inst_address), 32'd0);
        check("arst_ir",    32'(bus.inst_out),     32'd0);
        check("arst_irpc",  32'(bus.ir_pc),        32'd0);
        check("arst_valid", 32'(bus.inst_valid),   32'd0);
        check("arst_busy",  32'(bus.busy),         32'd0);
        check("arst_cnt",   32'(bus.cycle_count),  32'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_idle", 32'(bus.busy), 32'd0);

        // PC wrap from 1023 to 0
        bus.start = 1'b1; bus.start_addr = 10'd1023;
        step();
        bus.start = 1'b0;
        step();
        check("wrap_irpc1023", 32'(bus.ir_pc),        32'd1023);
        check("wrap_valid0",   32'(bus.inst_valid),   32'd1);
        check("wrap_pc",       32'(bus.inst_address), 32'd0);
        step();
        check("wrap_irpc0", 32'(bus.ir_pc),      32'd0);
        check("wrap_ir0",   32'(bus.inst_out),   32'(rom_f(10'd0)));
        check("wrap_valid", 32'(bus.inst_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
